// File: rtl/rls_fixed_pkg.sv
// rls_fixed_pkg: shared fixed-point defaults, accumulator sizing and FSM state type.
// Rev 1.0
`default_nettype none

package rls_fixed_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 16;

  localparam logic [31:0] Q16_16_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] Q16_16_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } dp_state_t;

  // Full-precision products plus enough headroom to sum every element pair.
  function automatic int acc_width(input int width, input int size_b);
    return 2 * width + $clog2(size_b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/dot_mac_lane.sv
// dot_mac_lane: combinational signed sum of COMBSIZE full-precision element products.
// Rev 1.0
`default_nettype none

module dot_mac_lane #(
  parameter int WIDTH    = 32,
  parameter int COMBSIZE = 4,
  parameter int SUM_W    = 2 * WIDTH + 4
) (
  input  logic [WIDTH*COMBSIZE-1:0] a_chunk,
  input  logic [WIDTH*COMBSIZE-1:0] b_chunk,
  output logic [SUM_W-1:0]          sum
);

  logic signed [WIDTH-1:0]   ea;
  logic signed [WIDTH-1:0]   eb;
  logic signed [2*WIDTH-1:0] prod;

  always_comb begin
    sum  = '0;
    ea   = '0;
    eb   = '0;
    prod = '0;
    for (int i = 0; i < COMBSIZE; i++) begin
      ea   = a_chunk[WIDTH*i +: WIDTH];
      eb   = b_chunk[WIDTH*i +: WIDTH];
      prod = ea * eb;
      sum  = sum + {{(SUM_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    end
  end

endmodule

`default_nettype wire

// File: rtl/vector_dot_product.sv
// vector_dot_product: multi-cycle fixed-point dot product, COMBSIZE pairs per cycle.
// Optional macro VECTOR_DOT_PRODUCT_SATURATE_EN clamps y to the WIDTH-bit signed range.
`default_nettype none

module vector_dot_product
  import rls_fixed_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int SIZE_B   = 16,
  parameter int COMBSIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH*SIZE_B-1:0] a,
  input  logic [WIDTH*SIZE_B-1:0] b,
  output logic [WIDTH-1:0]        y,
  output logic                    busy,
  output logic                    done
);

  localparam int ACC_W   = acc_width(WIDTH, SIZE_B);
  localparam int NCHUNK  = SIZE_B / COMBSIZE;
  localparam int CNT_W   = $clog2(NCHUNK + 1);
  localparam int CHUNK_W = WIDTH * COMBSIZE;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK);

  dp_state_t               state;
  dp_state_t               state_d;
  logic [WIDTH*SIZE_B-1:0] a_q;
  logic [WIDTH*SIZE_B-1:0] b_q;
  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;
  logic [WIDTH-1:0]        y_q;
  logic [CNT_W-1:0]        chunk_idx;
  logic [ACC_W-1:0]        lane_sum;
  logic [WIDTH-1:0]        y_next;

  assign chunk_idx = (cnt < LAST) ? cnt : '0;

  dot_mac_lane #(
    .WIDTH    (WIDTH),
    .COMBSIZE (COMBSIZE),
    .SUM_W    (ACC_W)
  ) u_lane (
    .a_chunk (a_q[chunk_idx*CHUNK_W +: CHUNK_W]),
    .b_chunk (b_q[chunk_idx*CHUNK_W +: CHUNK_W]),
    .sum     (lane_sum)
  );

`ifdef VECTOR_DOT_PRODUCT_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  always_comb begin
    y_next = WIDTH'(acc >>> FRAC);
    if ((acc >>> FRAC) > SAT_MAX) begin
      y_next = {1'b0, {(WIDTH-1){1'b1}}};
    end else if ((acc >>> FRAC) < SAT_MIN) begin
      y_next = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  always_comb begin
    y_next = WIDTH'(acc >>> FRAC);
  end
`endif

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (cnt == LAST) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      cnt   <= '0;
      y_q   <= '0;
    end else begin
      state <= state_d;
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_q <= a;
            b_q <= b;
            acc <= '0;
            cnt <= '0;
          end
        end
        ST_RUN: begin
          // Once every chunk is in, y is taken from the settled accumulator.
          if (cnt != LAST) begin
            acc <= acc + $signed(lane_sum);
            cnt <= cnt + 1'b1;
          end else begin
            y_q <= y_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign y    = y_q;
  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

`default_nettype wire
